// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one SRAM-like memory port (req/addr_ok/data_ok) between the fetch
// requester (inst_*) and the data requester (data_*). At most one transaction
// is in flight. Each response is routed back to the requester that issued it.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   - a tie in IDLE is granted to the requester that did not win
//               the previous grant (last_grant resets to fetch).
//   undefined - fixed priority; the data requester always wins a tie.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  // fetch requester
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  // data requester
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  input  logic [DATA_W/8-1:0] data_wstrb,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  // shared memory port
  output logic                mem_req,
  output logic                mem_wr,
  output logic [1:0]          mem_size,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  state_t state;
  state_t state_n;
  logic   owner;
  logic   owner_n;
  logic   grant;
  logic   owner_req;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant;

  // Remember who won the most recent grant so the next tie goes the other way.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_grant <= OWN_INST;
    end else if (state == IDLE && (inst_req || data_req)) begin
      last_grant <= grant;
    end
  end

  // Round-robin pick: a tie goes to whoever did not win last time.
  always_comb begin
    grant = OWN_INST;
    if (inst_req && data_req) begin
      grant = (last_grant == OWN_INST) ? OWN_DATA : OWN_INST;
    end else if (data_req) begin
      grant = OWN_DATA;
    end
  end
`else
  // Fixed priority: data wins any tie, so a held data_req can starve fetch.
  always_comb begin
    grant = data_req ? OWN_DATA : OWN_INST;
  end
`endif

  // State and owner registers; owner only changes when leaving IDLE.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      owner <= OWN_INST;
    end else begin
      state <= state_n;
      owner <= owner_n;
    end
  end

  // Next-state logic and the combinational mux of the shared port.
  always_comb begin
    state_n      = state;
    owner_n      = owner;
    owner_req    = (owner == OWN_DATA) ? data_req : inst_req;
    mem_req      = 1'b0;
    mem_wr       = 1'b0;
    mem_size     = 2'd0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_wstrb    = '0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = '0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = '0;

    unique case (state)
      IDLE: begin
        // Arbitrate only; the request goes out on the following cycle.
        if (inst_req || data_req) begin
          owner_n = grant;
          state_n = ADDR;
        end
      end

      ADDR: begin
        mem_req = owner_req;
        if (owner == OWN_DATA) begin
          mem_wr    = data_wr;
          mem_size  = data_size;
          mem_addr  = data_addr;
          mem_wdata = data_wdata;
          mem_wstrb = data_wstrb;
        end else begin
          // Fetch is always a word read with no write payload.
          mem_size  = 2'd2;
          mem_addr  = inst_addr;
        end
        if (!owner_req) begin
          // Owner withdrew its request: abandon without a transaction.
          state_n = IDLE;
        end else if (mem_addr_ok) begin
          if (owner == OWN_DATA) begin
            data_addr_ok = 1'b1;
          end else begin
            inst_addr_ok = 1'b1;
          end
          state_n = RESP;
        end
      end

      RESP: begin
        if (owner == OWN_DATA) begin
          data_rdata   = mem_rdata;
          data_data_ok = mem_data_ok;
        end else begin
          inst_rdata   = mem_rdata;
          inst_data_ok = mem_data_ok;
        end
        if (mem_data_ok) begin
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter. Inputs change 1 ns after the
// rising edge; outputs are checked on the falling edge.
module tb_mem_port_arbiter;

  logic        clk;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  int vectors;
  int errs;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // move to the falling edge for sampling
  task automatic mid();
    @(negedge clk);
  endtask

  task automatic quiet();
    inst_req    = 1'b0;
    data_req    = 1'b0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
  endtask

  initial begin
    vectors = 0;
    errs    = 0;
    resetn  = 1'b0;
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = '0;
    data_wdata = '0; data_wstrb = '0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
    nxt(); nxt();
    resetn = 1'b1;
    mid();
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_oks", {28'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 32'd0);

    // T1: single fetch
    nxt(); inst_req = 1'b1; inst_addr = 32'h1C00_0000;
    mid(); chk("t1_idle_mem_req", {31'd0, mem_req}, 32'd0);
    nxt(); mem_addr_ok = 1'b1;
    mid();
    chk("t1_mem_req", {31'd0, mem_req}, 32'd1);
    chk("t1_mem_addr", mem_addr, 32'h1C00_0000);
    chk("t1_mem_size", {30'd0, mem_size}, 32'd2);
    chk("t1_mem_wr_wstrb", {27'd0, mem_wr, mem_wstrb}, 32'd0);
    chk("t1_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'b10);
    nxt(); inst_req = 1'b0; mem_addr_ok = 1'b0;
    mid(); chk("t1_resp_wait", {30'd0, mem_req, inst_data_ok}, 32'd0);
    nxt(); mem_data_ok = 1'b1; mem_rdata = 32'h0280_0413;
    mid();
    chk("t1_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'b10);
    chk("t1_rdata", inst_rdata, 32'h0280_0413);
    nxt(); mem_data_ok = 1'b0;
    mid(); chk("t1_done", {31'd0, inst_data_ok}, 32'd0);

    // T2: simultaneous requests, data wins the first tie
    nxt(); inst_req = 1'b1; inst_addr = 32'h1C00_0040;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h1C00_1000;
    mid(); chk("t2_idle", {30'd0, mem_req, inst_addr_ok}, 32'd0);
    nxt(); mem_addr_ok = 1'b1;
    mid();
    chk("t2_mem_addr_d", mem_addr, 32'h1C00_1000);
    chk("t2_addr_ok_d", {30'd0, inst_addr_ok, data_addr_ok}, 32'b01);
    nxt(); data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h1122_3344;
    mid();
    chk("t2_data_ok_d", {30'd0, inst_data_ok, data_data_ok}, 32'b01);
    chk("t2_rdata_d", data_rdata, 32'h1122_3344);
    chk("t2_no_inst_ok", {31'd0, inst_addr_ok}, 32'd0);
    nxt(); mem_data_ok = 1'b0;
    mid(); chk("t2_idle2", {30'd0, mem_req, inst_addr_ok}, 32'd0);
    nxt(); mem_addr_ok = 1'b1;
    mid();
    chk("t2_mem_addr_i", mem_addr, 32'h1C00_0040);
    chk("t2_addr_ok_i", {30'd0, inst_addr_ok, data_addr_ok}, 32'b10);
    nxt(); inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0000_0055;
    mid();
    chk("t2_data_ok_i", {30'd0, inst_data_ok, data_data_ok}, 32'b10);
    chk("t2_rdata_i", inst_rdata, 32'h0000_0055);
    nxt(); quiet();

    // T3: half-word write
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd1; data_addr = 32'h1C00_2002;
    data_wdata = 32'hBEEF_0000; data_wstrb = 4'b1100;
    nxt(); mem_addr_ok = 1'b1;
    mid();
    chk("t3_mem_wr", {31'd0, mem_wr}, 32'd1);
    chk("t3_mem_size", {30'd0, mem_size}, 32'd1);
    chk("t3_mem_wstrb", {28'd0, mem_wstrb}, 32'hC);
    chk("t3_mem_addr", mem_addr, 32'h1C00_2002);
    chk("t3_mem_wdata", mem_wdata, 32'hBEEF_0000);
    chk("t3_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'b01);
    nxt(); data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    mid(); chk("t3_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'b01);
    nxt(); quiet(); data_wr = 1'b0;

    // T4: memory stalls address acceptance for 5 cycles
    inst_req = 1'b1; inst_addr = 32'h1C00_0080;
    nxt();
    for (int i = 0; i < 5; i++) begin
      mid();
      chk("t4_stall_req", {31'd0, mem_req}, 32'd1);
      chk("t4_stall_addr", mem_addr, 32'h1C00_0080);
      chk("t4_stall_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
      nxt();
    end
    mem_addr_ok = 1'b1;
    mid(); chk("t4_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    nxt(); inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0000_0077;
    mid(); chk("t4_data_ok", {31'd0, inst_data_ok}, 32'd1);
    nxt(); quiet();

    // T5: reset during RESP drops the pending response
    data_req = 1'b1; data_addr = 32'h1C00_3000;
    nxt(); mem_addr_ok = 1'b1;
    mid(); chk("t5_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    nxt(); data_req = 1'b0; mem_addr_ok = 1'b0; resetn = 1'b0;
    nxt(); resetn = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    mid();
    chk("t5_no_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    chk("t5_mem_req", {31'd0, mem_req}, 32'd0);
    nxt(); mem_data_ok = 1'b0;
    mid(); chk("t5_mem_req2", {31'd0, mem_req}, 32'd0);

    // T6: both requests held across 4 transactions
    nxt(); inst_req = 1'b1; data_req = 1'b1; data_addr = 32'h1C00_4000; inst_addr = 32'h1C00_00C0;
    for (int k = 0; k < 4; k++) begin
      logic exp_d;
`ifdef ARB_ROUND_ROBIN_EN
      exp_d = (k % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      nxt(); mem_addr_ok = 1'b1;
      mid();
      chk("t6_grant", {30'd0, inst_addr_ok, data_addr_ok}, {30'd0, ~exp_d, exp_d});
      chk("t6_addr", mem_addr, exp_d ? 32'h1C00_4000 : 32'h1C00_00C0);
      nxt(); mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
      mid();
      chk("t6_resp", {30'd0, inst_data_ok, data_data_ok}, {30'd0, ~exp_d, exp_d});
      nxt(); mem_data_ok = 1'b0;
    end
    quiet();
    nxt();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
